frontend_cmd_arbiter: RTL

Round-robin arbiter that shares the single-rank backend controller command channel among `NUM_REQ` frontend requesters. It buffers write data in grant order, tracks outstanding reads with an in-order tag FIFO, and steers returned read data to the issuing requester. It sits between the frontend request sources and the backend controller's command, write-data and read-return channels. It optionally favours row-hit commands, with a starvation cap.

---
 rtl/frontend_cmd_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/frontend_cmd_arbiter.sv
// frontend_cmd_arbiter: round-robin arbiter for the backend command channel, with an in-order write-data FIFO
// and a read-tag FIFO that steers read returns. Row-hit priority is enabled by FRONTEND_ARB_ROW_HIT_PRIORITY_EN.
`ifndef DQ_BITS
`define DQ_BITS 4
`endif
`ifndef FRONTEND_CMD_BITS
`define FRONTEND_CMD_BITS 30
`endif

module frontend_cmd_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TAG_DEPTH    = 8,
    parameter int WDATA_DEPTH  = 8,
    parameter int STARVE_LIMIT = 7
) (
    input  logic                                  clk,
    input  logic                                  power_on_rst_n,
    input  logic [NUM_REQ-1:0]                    i_req_valid,
    input  logic [NUM_REQ*`FRONTEND_CMD_BITS-1:0] i_req_cmd,
    input  logic [NUM_REQ*`DQ_BITS*8-1:0]         i_req_wdata,
    output logic [NUM_REQ-1:0]                    o_req_ready,
    output logic [NUM_REQ-1:0]                    o_rsp_valid,
    output logic [`DQ_BITS*8-1:0]                 o_rsp_data,
    input  logic [NUM_REQ-1:0]                    i_rsp_ready,
    output logic                                  o_frontend_command_valid,
    output logic [`FRONTEND_CMD_BITS-1:0]         o_frontend_command,
    input  logic                                  i_backend_controller_ready,
    output logic [`DQ_BITS*8-1:0]                 o_frontend_write_data,
    input  logic                                  i_backend_controller_ren,
    input  logic                                  i_backend_read_data_valid,
    input  logic [`DQ_BITS*8-1:0]                 i_backend_read_data,
    output logic                                  o_backend_controller_stall,
    output logic [1:0]                            o_err
);
    localparam int CW = `FRONTEND_CMD_BITS;
    localparam int DW = `DQ_BITS * 8;
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TAG_DEPTH);
    localparam int WW = $clog2(WDATA_DEPTH);
    localparam logic [1:0] OP_READ = 2'd1;

    typedef struct packed {
        logic [1:0]     op_type;
        logic [15:0]    row_addr;
        logic [CW-19:0] col_addr;
    } frontend_command_t;

    if (NUM_REQ < 2 || STARVE_LIMIT < 1 || (1 << TW) != TAG_DEPTH || (1 << WW) != WDATA_DEPTH) begin : g_cfg_err
        $error("frontend_cmd_arbiter: unsupported parameter set");
    end

    // First set bit of m at or after p (wrapping); MSB flags that one was found.
    function automatic logic [IW:0] pick(input logic [NUM_REQ-1:0] m, input logic [IW-1:0] p);
        logic [IW:0] r;
        logic [IW:0] idx;
        r = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, p} + (IW+1)'(i);
            if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
            if (m[idx[IW-1:0]]) r = {1'b1, idx[IW-1:0]};
        end
        return r;
    endfunction

    frontend_command_t  req_cmd [NUM_REQ];
    frontend_command_t  gnt_cmd, cmd_q;
    logic [NUM_REQ-1:0] elig;
    logic [IW-1:0]      rr_q, rr_d, gnt_idx;
    logic [IW:0]        rr_pick;
    logic               cmd_vld_q, load, gnt, gnt_rd;
    logic [TW:0]        tag_wr_q, tag_rd_q;
    logic [IW-1:0]      tag_mem [TAG_DEPTH];
    logic [IW-1:0]      tag_head;
    logic               tag_full, tag_empty, tag_push, tag_pop;
    logic [WW:0]        wd_wr_q, wd_rd_q;
    logic [DW-1:0]      wd_mem [WDATA_DEPTH];
    logic               wd_full, wd_empty, wd_push, wd_pop;
    logic [1:0]         err_q;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_cmd[k] = frontend_command_t'(i_req_cmd[k*CW +: CW]);
            elig[k]    = i_req_valid[k] && ((req_cmd[k].op_type == OP_READ) ? !tag_full : !wd_full);
        end
    end

    assign load    = !cmd_vld_q || i_backend_controller_ready;
    assign rr_pick = pick(elig, rr_q);
    assign gnt     = power_on_rst_n && load && rr_pick[IW];

`ifdef FRONTEND_ARB_ROW_HIT_PRIORITY_EN
    localparam int SW = $clog2(STARVE_LIMIT + 2);
    logic [15:0]        last_row_q;
    logic               last_row_vld_q, use_hit;
    logic [SW-1:0]      starve_q;
    logic [NUM_REQ-1:0] hit;
    logic [IW:0]        hit_pick;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++)
            hit[k] = elig[k] && last_row_vld_q && (req_cmd[k].row_addr == last_row_q);
    end

    assign hit_pick = pick(hit, rr_q);
    assign use_hit  = hit_pick[IW] && (starve_q != SW'(STARVE_LIMIT));
    assign gnt_idx  = use_hit ? hit_pick[IW-1:0] : rr_pick[IW-1:0];

    // Only a hit that overtakes the round-robin choice counts towards starvation.
    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            last_row_q     <= '0;
            last_row_vld_q <= 1'b0;
            starve_q       <= '0;
        end else if (gnt) begin
            last_row_q     <= gnt_cmd.row_addr;
            last_row_vld_q <= 1'b1;
            starve_q       <= (use_hit && hit_pick[IW-1:0] != rr_pick[IW-1:0]) ? starve_q + 1'b1 : '0;
        end
    end
`else
    assign gnt_idx = rr_pick[IW-1:0];
`endif

    assign gnt_cmd     = req_cmd[gnt_idx];
    assign gnt_rd      = gnt_cmd.op_type == OP_READ;
    assign rr_d        = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign o_req_ready = gnt ? NUM_REQ'(1) << gnt_idx : '0;

    assign o_frontend_command_valid = cmd_vld_q;
    assign o_frontend_command       = cmd_q;

    assign tag_empty = tag_wr_q == tag_rd_q;
    assign tag_full  = tag_wr_q == {~tag_rd_q[TW], tag_rd_q[TW-1:0]};
    assign tag_head  = tag_mem[tag_rd_q[TW-1:0]];
    assign tag_push  = gnt && gnt_rd;
    assign tag_pop   = i_backend_read_data_valid && !tag_empty && i_rsp_ready[tag_head];

    assign wd_empty = wd_wr_q == wd_rd_q;
    assign wd_full  = wd_wr_q == {~wd_rd_q[WW], wd_rd_q[WW-1:0]};
    assign wd_push  = gnt && !gnt_rd;
    assign wd_pop   = i_backend_controller_ren && !wd_empty;

    assign o_rsp_valid                = (i_backend_read_data_valid && !tag_empty) ? NUM_REQ'(1) << tag_head : '0;
    assign o_rsp_data                 = power_on_rst_n ? i_backend_read_data : '0;
    assign o_backend_controller_stall = !tag_empty && !i_rsp_ready[tag_head];
    assign o_frontend_write_data      = wd_empty ? '0 : wd_mem[wd_rd_q[WW-1:0]];
    assign o_err                      = err_q;

    always_ff @(posedge clk) begin
        if (tag_push) tag_mem[tag_wr_q[TW-1:0]] <= gnt_idx;
        if (wd_push) wd_mem[wd_wr_q[WW-1:0]] <= i_req_wdata[gnt_idx*DW +: DW];
    end

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            cmd_vld_q <= 1'b0;
            cmd_q     <= '0;
            rr_q      <= '0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            wd_wr_q   <= '0;
            wd_rd_q   <= '0;
            err_q     <= '0;
        end else begin
            if (load) cmd_vld_q <= gnt;
            if (gnt) begin
                cmd_q <= gnt_cmd;
                rr_q  <= rr_d;
            end
            if (tag_push) tag_wr_q <= tag_wr_q + 1'b1;
            if (tag_pop) tag_rd_q <= tag_rd_q + 1'b1;
            if (wd_push) wd_wr_q <= wd_wr_q + 1'b1;
            if (wd_pop) wd_rd_q <= wd_rd_q + 1'b1;
            if (i_backend_controller_ren && wd_empty) err_q[0] <= 1'b1;
            if (i_backend_read_data_valid && tag_empty) err_q[1] <= 1'b1;
        end
    end
endmodule
